piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter; counterpart of the team's serial-in

---
 rtl/piso_serializer_pkg.sv | 11 +
 rtl/piso_serializer_bit_counter.sv | 23 ++
 rtl/piso_serializer.sv | 98 +++++++++
 tb/tb_piso_serializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO transmitter and its receive-side partner.
// Parity frame extension is compiled in when PISO_PARITY_EN is defined.
package piso_serializer_pkg;
  localparam int PISO_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter: synchronous clear/load to zero, saturates at N-1.
module piso_serializer_bit_counter #(
  parameter int N = 8
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic                   i_en,
  output logic [$clog2(N+1)-1:0] o_cnt,
  output logic                   o_tc
);
  localparam int CNTW = $clog2(N+1);

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr || i_load) r_cnt <= '0;
    else if (i_en && !o_tc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNTW'(N - 1));
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, valid/ready load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N = PISO_DEF_WIDTH
) (
  input  logic         i_cp,
  input  logic         i_clr,
  input  logic [N-1:0] i_di,
  input  logic         i_ld,
  output logic         o_rdy,
  output logic         o_do,
  output logic         o_vld,
  output logic         o_frm,
  output logic         o_done
);
  localparam int CNTW = $clog2(N+1);

  state_t          r_state, w_next;
  logic [N-1:0]    r_sreg;
  logic [CNTW-1:0] w_cnt;
  logic            w_tc;
  logic            w_accept;
`ifdef PISO_PARITY_EN
  logic            r_par;
`endif

  assign w_accept = i_ld && o_rdy;

  piso_serializer_bit_counter #(.N(N)) u_cnt (
    .i_clk  (i_cp),
    .i_clr  (i_clr),
    .i_load (w_accept),
    .i_en   (r_state == ST_SHIFT),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  // Outputs decode straight from registered state so RDY can open in the
  // final bit cycle and a new word follows with no bubble.
  always_comb begin
    w_next = r_state;
    o_rdy  = 1'b0;
    o_vld  = 1'b0;
    o_do   = 1'b0;
    o_frm  = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_rdy = 1'b1;
        if (i_ld) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_vld = 1'b1;
        o_do  = r_sreg[N-1];
        o_frm = (w_cnt == '0);
        if (w_tc) begin
`ifdef PISO_PARITY_EN
          w_next = ST_PARITY;
`else
          o_done = 1'b1;
          o_rdy  = 1'b1;
          w_next = i_ld ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        o_vld  = 1'b1;
        o_do   = r_par;
        o_done = 1'b1;
        o_rdy  = 1'b1;
        w_next = i_ld ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_cp) begin
    if (i_clr) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_sreg <= i_di;
      else if (r_state == ST_SHIFT) r_sreg <= {r_sreg[N-2:0], 1'b0};
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge i_cp) begin
    if (i_clr) r_par <= 1'b0;
    else if (w_accept) r_par <= ^i_di;
  end
`endif
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle output scoreboard plus a
// SIPO-style loopback that reassembles each transmitted word.
module tb_piso_serializer;
  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FR = N + (PAR ? 1 : 0);

  typedef struct packed {
    logic vld;
    logic dout;
    logic frm;
    logic done;
    logic rdy;
  } rec_t;

  localparam rec_t IDLE_REC = '{vld: 1'b0, dout: 1'b0, frm: 1'b0, done: 1'b0, rdy: 1'b1};

  logic         clk = 1'b0;
  logic         clr, ld;
  logic [N-1:0] di;
  logic         rdy, dout, vld, frm, done;

  rec_t         sb[$];
  logic [N-1:0] words[$];
  logic [N-1:0] rx_sr;
  int           rx_cnt;
  int           tests, fails, cyc;

  piso_serializer #(.N(N)) dut (
    .i_cp   (clk),
    .i_clr  (clr),
    .i_di   (di),
    .i_ld   (ld),
    .o_rdy  (rdy),
    .o_do   (dout),
    .o_vld  (vld),
    .o_frm  (frm),
    .o_done (done)
  );

  always #5 clk = ~clk;

  // Queue the expected per-cycle outputs of one accepted word.
  task automatic push_word(input logic [N-1:0] w);
    rec_t r;
    for (int k = 0; k < N; k++) begin
      r.vld  = 1'b1;
      r.dout = w[N-1-k];
      r.frm  = (k == 0);
      r.done = (k == N - 1) && !PAR;
      r.rdy  = (k == N - 1) && !PAR;
      sb.push_back(r);
    end
    if (PAR) begin
      r.vld = 1'b1; r.dout = ^w; r.frm = 1'b0; r.done = 1'b1; r.rdy = 1'b1;
      sb.push_back(r);
    end
    words.push_back(w);
  endtask

  task automatic tick();
    rec_t         exp_r, obs_r;
    logic [N-1:0] exp_w;
    @(posedge clk);
    #1;
    cyc++;
    exp_r = IDLE_REC;
    if (sb.size() > 0) exp_r = sb.pop_front();
    obs_r = {vld, dout, frm, done, rdy};
    tests++;
    assert (obs_r === exp_r) else begin
      fails++;
      $error("FAIL outputs cyc=%0d obs{vld,do,frm,done,rdy}=%b exp=%b", cyc, obs_r, exp_r);
    end
    if (vld === 1'b1) begin
      if (rx_cnt < N) rx_sr = {rx_sr[N-2:0], dout};
      rx_cnt++;
    end
    if (done === 1'b1) begin
      exp_w = 'x;
      if (words.size() > 0) exp_w = words.pop_front();
      tests++;
      assert (rx_sr === exp_w) else begin
        fails++;
        $error("FAIL loopback cyc=%0d got=%h exp=%h", cyc, rx_sr, exp_w);
      end
      rx_cnt = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; rx_cnt = 0; rx_sr = '0;
    clr = 1'b1; ld = 1'b0; di = '0;

    // reset
    ticks(2);
    clr = 1'b0;
    ticks(1);

    // single word A5
    di = 8'hA5; ld = 1'b1; push_word(8'hA5);
    tick();
    ld = 1'b0;
    ticks(FR - 1);
    ticks(2);

    // back-to-back A5 then 3C with LD held
    di = 8'hA5; ld = 1'b1; push_word(8'hA5);
    tick();
    ticks(FR - 1);
    di = 8'h3C; push_word(8'h3C);
    tick();
    ld = 1'b0;
    ticks(FR - 1);
    ticks(2);

    // LD while busy is ignored
    di = 8'hA5; ld = 1'b1; push_word(8'hA5);
    tick();
    ld = 1'b0;
    ticks(2);
    di = 8'hFF; ld = 1'b1;
    tick();
    ld = 1'b0; di = '0;
    ticks(FR - 4);
    ticks(2);

    // CLR mid-frame, with a simultaneous LD that must be dropped
    di = 8'hA5; ld = 1'b1; push_word(8'hA5);
    tick();
    ld = 1'b0;
    ticks(3);
    clr = 1'b1; ld = 1'b1; di = 8'hFF;
    sb.delete(); words.delete(); rx_cnt = 0;
    tick();
    clr = 1'b0; ld = 1'b0;
    tick();
    di = 8'h81; ld = 1'b1; push_word(8'h81);
    tick();
    ld = 1'b0;
    ticks(FR - 1);
    ticks(1);

    // odd parity source word, then idle drain
    di = 8'h07; ld = 1'b1; push_word(8'h07);
    tick();
    ld = 1'b0;
    ticks(FR - 1);
    ticks(3);

    tests++;
    assert (sb.size() == 0 && words.size() == 0) else begin
      fails++;
      $error("FAIL drain sb=%0d words=%0d exp=0", sb.size(), words.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
